// File: rtl/alu.sv
// Single-cycle RV32-style ALU with registered result and branch-taken flag.
// Latency 1 cycle, one operation accepted every cycle, no backpressure.
module alu (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ALU_Control,
  input  logic [31:0] operand_A,
  input  logic [31:0] operand_B,
  input  logic        branch_op,
  output logic [31:0] ALU_result,
  output logic        branch
);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b001000;
  localparam logic [5:0] OP_SLL  = 6'b000001;
  localparam logic [5:0] OP_SRL  = 6'b000101;
  localparam logic [5:0] OP_SRA  = 6'b001101;
  localparam logic [5:0] OP_SLT  = 6'b000010;
  localparam logic [5:0] OP_SLTU = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_OR   = 6'b000110;
  localparam logic [5:0] OP_AND  = 6'b000111;
  localparam logic [5:0] OP_JAL  = 6'b011111;
  localparam logic [5:0] OP_BEQ  = 6'b010000;
  localparam logic [5:0] OP_BNE  = 6'b010001;
  localparam logic [5:0] OP_BLT  = 6'b010100;
  localparam logic [5:0] OP_BGE  = 6'b010101;
  localparam logic [5:0] OP_BLTU = 6'b010110;
  localparam logic [5:0] OP_BGEU = 6'b010111;

  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic        cond;
  logic        is_cmp;
  logic [31:0] result_d;
  logic        branch_d;

  // Only the low five bits of B select the shift distance.
  assign shamt = operand_B[4:0];
  assign lt_s  = $signed(operand_A) < $signed(operand_B);
  assign lt_u  = operand_A < operand_B;
  assign eq    = operand_A == operand_B;

  always_comb begin
    cond   = 1'b0;
    is_cmp = 1'b0;
    case (ALU_Control)
      OP_BEQ:  begin is_cmp = 1'b1; cond = eq;    end
      OP_BNE:  begin is_cmp = 1'b1; cond = !eq;   end
      OP_BLT:  begin is_cmp = 1'b1; cond = lt_s;  end
      OP_BGE:  begin is_cmp = 1'b1; cond = !lt_s; end
      OP_BLTU: begin is_cmp = 1'b1; cond = lt_u;  end
      OP_BGEU: begin is_cmp = 1'b1; cond = !lt_u; end
      default: begin is_cmp = 1'b0; cond = 1'b0;  end
    endcase
  end

  always_comb begin
    result_d = 32'd0;
    branch_d = 1'b0;
    if (is_cmp) begin
      result_d = {31'd0, cond};
      branch_d = branch_op & cond;
    end else begin
      case (ALU_Control)
        OP_ADD: begin
          result_d = operand_A + operand_B;
          branch_d = branch_op;
        end
        OP_SUB:  result_d = operand_A - operand_B;
        OP_SLL:  result_d = operand_A << shamt;
        OP_SRL:  result_d = operand_A >> shamt;
        OP_SRA:  result_d = $unsigned($signed(operand_A) >>> shamt);
        OP_SLT:  result_d = {31'd0, lt_s};
        OP_SLTU: result_d = {31'd0, lt_u};
        OP_XOR:  result_d = operand_A ^ operand_B;
        OP_OR:   result_d = operand_A | operand_B;
        OP_AND:  result_d = operand_A & operand_B;
        OP_JAL: begin
          result_d = operand_A;
          branch_d = branch_op;
        end
        default: begin
          result_d = 32'd0;
          branch_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ALU_result <= 32'd0;
      branch     <= 1'b0;
    end else begin
      ALU_result <= result_d;
      branch     <= branch_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expected results queued at drive time, popped one cycle later.
module tb_alu;

  localparam logic [5:0] ADD  = 6'b000000;
  localparam logic [5:0] SUB  = 6'b001000;
  localparam logic [5:0] SLL  = 6'b000001;
  localparam logic [5:0] SRL  = 6'b000101;
  localparam logic [5:0] SRA  = 6'b001101;
  localparam logic [5:0] SLT  = 6'b000010;
  localparam logic [5:0] SLTU = 6'b000011;
  localparam logic [5:0] XOR_ = 6'b000100;
  localparam logic [5:0] OR_  = 6'b000110;
  localparam logic [5:0] AND_ = 6'b000111;
  localparam logic [5:0] JAL  = 6'b011111;
  localparam logic [5:0] BEQ  = 6'b010000;
  localparam logic [5:0] BNE  = 6'b010001;
  localparam logic [5:0] BLT  = 6'b010100;
  localparam logic [5:0] BGE  = 6'b010101;
  localparam logic [5:0] BLTU = 6'b010110;
  localparam logic [5:0] BGEU = 6'b010111;

  logic        clock;
  logic        reset;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic        branch_op;
  logic [31:0] ALU_result;
  logic        branch;

  int n_tests;
  int n_fail;
  logic drv_vld;

  logic [31:0] sb_res[$];
  logic        sb_br[$];
  string       sb_tag[$];

  alu dut (
    .clock      (clock),
    .reset      (reset),
    .ALU_Control(ALU_Control),
    .operand_A  (operand_A),
    .operand_B  (operand_B),
    .branch_op  (branch_op),
    .ALU_result (ALU_result),
    .branch     (branch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic [5:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic bop,
                    input logic [31:0] er, input logic eb);
    @(negedge clock);
    ALU_Control = c;
    operand_A   = a;
    operand_B   = b;
    branch_op   = bop;
    drv_vld     = 1'b1;
    sb_res.push_back(er);
    sb_br.push_back(eb);
    sb_tag.push_back(tag);
  endtask

  // Monitor: whatever was driven before this edge must appear just after it.
  always @(posedge clock) begin
    if (drv_vld && reset) begin
      #1;
      if (sb_res.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        string t;
        t = sb_tag.pop_front();
        chk({t, "_res"}, ALU_result, sb_res.pop_front());
        chk({t, "_br"}, {31'd0, branch}, {31'd0, sb_br.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [32:0] wide;
    n_tests     = 0;
    n_fail      = 0;
    drv_vld     = 1'b0;
    reset       = 1'b0;
    ALU_Control = ADD;
    operand_A   = 32'd4;
    operand_B   = 32'd5;
    branch_op   = 1'b1;

    #12;
    chk("rst_res", ALU_result, 32'd0);
    chk("rst_br", {31'd0, branch}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("first_edge_res", ALU_result, 32'd9);
    chk("first_edge_br", {31'd0, branch}, 32'd1);

    // Arithmetic / logic
    op("add",   ADD,  32'd4, 32'd5, 1'b0, 32'd9, 1'b0);
    op("sub",   SUB,  32'd4, 32'd5, 1'b0, 32'hFFFFFFFF, 1'b0);
    op("slt_a", SLT,  32'd4, 32'd5, 1'b0, 32'd1, 1'b0);
    op("slt_b", SLT,  32'd4, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0);
    op("sltu",  SLTU, 32'd4, 32'hFFFFFFFF, 1'b0, 32'd1, 1'b0);
    op("xor",   XOR_, 32'd4, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFB, 1'b0);
    op("and",   AND_, 32'd4, 32'hFFFFFFFF, 1'b0, 32'd4, 1'b0);
    op("or",    OR_,  32'd4, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0);
    op("slt_c", SLT,  32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 32'd1, 1'b0);
    op("sub_bop", SUB, 32'd4, 32'd5, 1'b1, 32'hFFFFFFFF, 1'b0);
    op("add_ovf", ADD, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd1, 1'b0);
    // Shifts
    op("srl",    SRL, 32'd24, 32'd3, 1'b0, 32'd3, 1'b0);
    op("sll",    SLL, 32'd24, 32'd1, 1'b0, 32'd48, 1'b0);
    op("sra",    SRA, 32'd24, 32'd1, 1'b0, 32'd12, 1'b0);
    op("sra_n",  SRA, 32'hFFFFFF80, 32'd1, 1'b0, 32'hFFFFFFC0, 1'b0);
    op("srl_n",  SRL, 32'hFFFFFF80, 32'd1, 1'b0, 32'h7FFFFFC0, 1'b0);
    op("sll_33", SLL, 32'd1, 32'd33, 1'b0, 32'd2, 1'b0);
    op("sll_0",  SLL, 32'h1234_5678, 32'h0000_0020, 1'b0, 32'h1234_5678, 1'b0);
    // Branches, positive operands
    op("jal_p",  JAL,  32'd4, 32'd3, 1'b1, 32'd4, 1'b1);
    op("jalr_p", ADD,  32'd4, 32'd3, 1'b1, 32'd7, 1'b1);
    op("beq_p",  BEQ,  32'd4, 32'd3, 1'b1, 32'd0, 1'b0);
    op("bne_p",  BNE,  32'd4, 32'd3, 1'b1, 32'd1, 1'b1);
    op("blt_p",  BLT,  32'd4, 32'd3, 1'b1, 32'd0, 1'b0);
    op("bge_p",  BGE,  32'd4, 32'd3, 1'b1, 32'd1, 1'b1);
    op("bltu_p", BLTU, 32'd4, 32'd3, 1'b1, 32'd0, 1'b0);
    op("bgeu_p", BGEU, 32'd4, 32'd3, 1'b1, 32'd1, 1'b1);
    op("beq_eq", BEQ,  32'd7, 32'd7, 1'b1, 32'd1, 1'b1);
    // Branches, negative operands, branch_op 1 then 0
    op("beq_n",  BEQ,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'd0, 1'b0);
    op("bne_n",  BNE,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'd1, 1'b1);
    op("blt_n",  BLT,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'd1, 1'b1);
    op("bge_n",  BGE,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'd0, 1'b0);
    op("bltu_n", BLTU, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'd1, 1'b1);
    op("bgeu_n", BGEU, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'd0, 1'b0);
    op("jalr_n", ADD,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFF9, 1'b1);
    op("bne_n0",  BNE,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 32'd1, 1'b0);
    op("blt_n0",  BLT,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 32'd1, 1'b0);
    op("bltu_n0", BLTU, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 32'd1, 1'b0);
    op("jalr_n0", ADD,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFF9, 1'b0);
    op("jal_n0",  JAL,  32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFC, 1'b0);
    // Undefined encodings
    op("undef_3f", 6'b111111, 32'd4, 32'd5, 1'b1, 32'd0, 1'b0);
    op("undef_09", 6'b001001, 32'd4, 32'd5, 1'b1, 32'd0, 1'b0);
    op("undef_18", 6'b011000, 32'd4, 32'd4, 1'b1, 32'd0, 1'b0);

    // Random ADD/SUB/SLTU against a 33-bit reference
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      wide = {1'b0, ra} + {1'b0, rb};
      op($sformatf("radd%0d", i), ADD, ra, rb, 1'b0, wide[31:0], 1'b0);
      wide = {1'b0, ra} - {1'b0, rb};
      op($sformatf("rsub%0d", i), SUB, ra, rb, 1'b0, wide[31:0], 1'b0);
      op($sformatf("rsltu%0d", i), SLTU, ra, rb, 1'b0, {31'd0, wide[32]}, 1'b0);
    end

    @(negedge clock);
    drv_vld = 1'b0;
    repeat (2) @(negedge clock);
    chk("sb_empty", sb_res.size(), 32'd0);

    // Latency: input change between edges must not reach the outputs early
    ALU_Control = ADD; operand_A = 32'd10; operand_B = 32'd20; branch_op = 1'b0;
    @(posedge clock); #1;
    chk("lat_base", ALU_result, 32'd30);
    @(negedge clock);
    ALU_Control = SUB; operand_A = 32'd50; operand_B = 32'd8;
    #1;
    chk("lat_hold", ALU_result, 32'd30);
    @(posedge clock); #1;
    chk("lat_upd", ALU_result, 32'd42);

    // Reset mid-cycle with ADD 4+5 pending
    @(negedge clock);
    ALU_Control = ADD; operand_A = 32'd4; operand_B = 32'd5; branch_op = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_res", ALU_result, 32'd0);
    chk("rst_mid_br", {31'd0, branch}, 32'd0);
    @(posedge clock); #1;
    chk("rst_hold_res", ALU_result, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_rel_hold", ALU_result, 32'd0);
    @(posedge clock); #1;
    chk("rst_rel_res", ALU_result, 32'd9);
    chk("rst_rel_br", {31'd0, branch}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: ALU

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ALU_Control  input  6  operation select (encodings in Function).
REQ-005 operand_A  input  32  first operand (rs1 / PC for jal).
REQ-006 operand_B  input  32  second operand (rs2 or immediate).
REQ-007 branch_op  input  1  1 = current instruction is a branch or jump; qualifies branch.
REQ-008 ALU_result  output  32  registered operation result.
REQ-009 branch  output  1  registered branch/jump-taken flag.

Function
REQ-010 Both outputs SHALL be registered: inputs sampled on rising clock edge, result visible after that edge; latency exactly 1 cycle; a new operation is accepted every cycle; no handshake.
REQ-011 Encodings, with the operation applied to A=operand_A and B=operand_B:
- 000000 ADD/JALR: A+B, modulo 2^32.
- 001000 SUB: A-B, modulo 2^32.
- 000001 SLL: A << B[4:0].
- 000101 SRL: A >> B[4:0], zero fill.
- 001101 SRA: A >>> B[4:0], sign fill from A[31].
- 000010 SLT: (signed A < signed B) ? 1 : 0.
- 000011 SLTU: (unsigned A < unsigned B) ? 1 : 0.
- 000100 XOR: A^B.
- 000110 OR: A|B.
- 000111 AND: A&B.
- 011111 JAL: A passed through unchanged.
- 010000 BEQ: A==B.
- 010001 BNE: A!=B.
- 010100 BLT: signed A < signed B.
- 010101 BGE: signed A >= signed B.
- 010110 BLTU: unsigned A < unsigned B.
- 010111 BGEU: unsigned A >= unsigned B.
REQ-012 For the six compare/branch codes (0101xx, 01000x), ALU_result SHALL be 32'd1 if the condition is true, otherwise 32'd0.
REQ-013 Branch flag:
- compare/branch codes: branch = branch_op AND condition.
- 011111 and 000000: branch = branch_op.
- all other codes: branch = 0.
REQ-014 Any encoding not listed SHALL produce ALU_result=0 and branch=0.
REQ-015 Shift amount SHALL use only B[4:0]; B[31:5] SHALL be ignored; shift by 0 returns A.
REQ-016 Overflow on ADD/SUB SHALL be discarded silently; no carry or overflow output.
REQ-017 Signed compares SHALL use two's complement; unsigned compares SHALL treat operands as 32-bit magnitudes (0xFFFFFFFC < 0xFFFFFFFD unsigned).
REQ-018 An unknown or X branch_op SHALL NOT be relied on; the bench drives it defined whenever branch is checked.

Reset
REQ-019 While reset=0, ALU_result SHALL be 0 and branch SHALL be 0 immediately, independent of clock.
REQ-020 Reset asserted mid-operation SHALL discard the pending result.
REQ-021 The first rising edge after reset deasserts SHALL register a normal result from the current inputs.
REQ-022 Reset SHALL have no other state; the block holds no multi-cycle state.

Verification
REQ-023 Arithmetic and logic: A=4, B=5:
- ADD -> 9; SUB -> -1 (0xFFFFFFFF); SLT -> 1.
- A=4, B=0xFFFFFFFF: SLT -> 0, SLTU -> 1, XOR -> 0xFFFFFFFB, AND -> 4, OR -> 0xFFFFFFFF.
- A=0xFFFFFFF0, B=0xFFFFFFFF: SLT -> 1.
REQ-024 Shifts:
- A=24, B=3: SRL -> 3.
- A=24, B=1: SLL -> 48, SRA -> 12.
- A=-128, B=1: SRA -> -64, SRL -> 0x7FFFFFC0.
- A=1, B=33: SLL -> 2.
REQ-025 Branches, A=4, B=3, branch_op=1:
- JAL -> result 4, branch 1; JALR -> 7, branch 1.
- BEQ -> 0/0; BNE -> 1/1; BLT -> 0/0; BGE -> 1/1; BLTU -> 0/0; BGEU -> 1/1.
REQ-026 Branches, A=-4, B=-3, branch_op=1:
- BEQ -> 0/0; BNE -> 1/1; BLT -> 1/1; BGE -> 0/0; BLTU -> 1/1; BGEU -> 0/0; JALR -> -7, branch 1.
- Same inputs with branch_op=0: branch=0 for every code, ALU_result unchanged.
REQ-027 Latency and reset:
- Change inputs between edges -> outputs change only at the next rising edge.
- Assert reset mid-cycle with ADD 4+5 pending -> outputs 0 at once.
- Release reset -> result 9 after the next edge.
- Encoding 111111 -> result 0, branch 0.
